// File: rtl/uart_cmd_parser.sv
// Frames UART receiver bytes (sync, opcode, 4 addr, 4 data) into DDR access commands
// presented on a valid/ready handshake; bad opcodes, stalls and overruns are flagged.
module uart_cmd_parser #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter logic [7:0]  OP_WRITE     = 8'h01,
  parameter logic [7:0]  OP_READ      = 8'h02,
  parameter int unsigned TIMEOUT_CLKS = 86800
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rx_dv,
  input  logic [7:0]  i_rx_byte,
  output logic        o_cmd_valid,
  input  logic        i_cmd_ready,
  output logic        o_cmd_wr,
  output logic [31:0] o_cmd_addr,
  output logic [31:0] o_cmd_wdata,
  output logic        o_err_frame,
  output logic        o_err_timeout,
  output logic        o_err_overrun
);

  localparam int unsigned GAP_W = $clog2(TIMEOUT_CLKS);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CLKS - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_OPCODE = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_ISSUE  = 3'd4;

  logic [2:0]       state, state_d;
  logic [1:0]       cnt, cnt_d;
  logic [GAP_W-1:0] gap, gap_d;
  logic             wr_d;
  logic [31:0]      addr_d, wdata_d;
  logic             err_frame_d, err_timeout_d, err_overrun_d;
  logic             timeout_hit;
  logic             active_d;

  // Next-state and next-output logic
  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    wr_d          = o_cmd_wr;
    addr_d        = o_cmd_addr;
    wdata_d       = o_cmd_wdata;
    err_frame_d   = 1'b0;
    err_timeout_d = 1'b0;
    err_overrun_d = 1'b0;
    timeout_hit   = (gap == GAP_LAST) && !i_rx_dv;

    case (state)
      ST_IDLE: begin
        if (i_rx_dv && (i_rx_byte == SYNC_BYTE)) state_d = ST_OPCODE;
      end
      ST_OPCODE: begin
        if (i_rx_dv) begin
          if (i_rx_byte == OP_WRITE) begin
            wr_d    = 1'b1;
            cnt_d   = 2'd0;
            state_d = ST_ADDR;
          end else if (i_rx_byte == OP_READ) begin
            wr_d    = 1'b0;
            cnt_d   = 2'd0;
            state_d = ST_ADDR;
          end else begin
            err_frame_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end else if (timeout_hit) begin
          err_timeout_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (i_rx_dv) begin
          addr_d = {o_cmd_addr[23:0], i_rx_byte};
          cnt_d  = cnt + 2'd1;
          if (cnt == 2'd3) begin
            if (o_cmd_wr) begin
              state_d = ST_DATA;
              cnt_d   = 2'd0;
            end else begin
              wdata_d = 32'd0;
              state_d = ST_ISSUE;
            end
          end
        end else if (timeout_hit) begin
          err_timeout_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (i_rx_dv) begin
          wdata_d = {o_cmd_wdata[23:0], i_rx_byte};
          cnt_d   = cnt + 2'd1;
          if (cnt == 2'd3) state_d = ST_ISSUE;
        end else if (timeout_hit) begin
          err_timeout_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // Bytes arriving while a command is pending are lost; sync must be re-acquired
        if (i_rx_dv) err_overrun_d = 1'b1;
        if (i_cmd_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    active_d = (state_d == ST_OPCODE) || (state_d == ST_ADDR) || (state_d == ST_DATA);
    gap_d    = (active_d && (state_d == state) && !i_rx_dv) ? gap + GAP_W'(1) : '0;
  end

  // State and registered outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state         <= ST_IDLE;
      cnt           <= 2'd0;
      gap           <= '0;
      o_cmd_valid   <= 1'b0;
      o_cmd_wr      <= 1'b0;
      o_cmd_addr    <= 32'd0;
      o_cmd_wdata   <= 32'd0;
      o_err_frame   <= 1'b0;
      o_err_timeout <= 1'b0;
      o_err_overrun <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      gap           <= gap_d;
      o_cmd_valid   <= (state_d == ST_ISSUE);
      o_cmd_wr      <= wr_d;
      o_cmd_addr    <= addr_d;
      o_cmd_wdata   <= wdata_d;
      o_err_frame   <= err_frame_d;
      o_err_timeout <= err_timeout_d;
      o_err_overrun <= err_overrun_d;
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed scenarios plus random frames, checked every cycle
// against a byte-counting frame model.
module tb_uart_cmd_parser;

  localparam int unsigned TO = 50;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_rx_dv;
  logic [7:0]  i_rx_byte;
  logic        o_cmd_valid;
  logic        i_cmd_ready;
  logic        o_cmd_wr;
  logic [31:0] o_cmd_addr;
  logic [31:0] o_cmd_wdata;
  logic        o_err_frame;
  logic        o_err_timeout;
  logic        o_err_overrun;

  uart_cmd_parser #(
    .SYNC_BYTE   (8'hA5),
    .OP_WRITE    (8'h01),
    .OP_READ     (8'h02),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_rx_dv      (i_rx_dv),
    .i_rx_byte    (i_rx_byte),
    .o_cmd_valid  (o_cmd_valid),
    .i_cmd_ready  (i_cmd_ready),
    .o_cmd_wr     (o_cmd_wr),
    .o_cmd_addr   (o_cmd_addr),
    .o_cmd_wdata  (o_cmd_wdata),
    .o_err_frame  (o_err_frame),
    .o_err_timeout(o_err_timeout),
    .o_err_overrun(o_err_overrun)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: counts frame bytes, idle cycles and the pending command
  int          m_len;
  int          m_idle;
  logic [7:0]  m_buf [10];
  bit          m_pending, m_wr;
  logic [31:0] m_addr, m_wdata;
  bit          e_frame, e_to, e_ov;

  always @(posedge i_clk) begin
    e_frame = 0; e_to = 0; e_ov = 0;
    if (!i_rst_n) begin
      m_len = 0; m_idle = 0; m_pending = 0; m_wr = 0; m_addr = 0; m_wdata = 0;
    end else if (m_pending) begin
      if (i_rx_dv) e_ov = 1;
      if (i_cmd_ready) m_pending = 0;
    end else if (m_len == 0) begin
      if (i_rx_dv && i_rx_byte == 8'hA5) begin
        m_len = 1; m_idle = 0;
      end
    end else if (i_rx_dv) begin
      m_idle = 0;
      if (m_len == 1) begin
        if (i_rx_byte == 8'h01 || i_rx_byte == 8'h02) begin
          m_wr = (i_rx_byte == 8'h01); m_len = 2;
        end else begin
          e_frame = 1; m_len = 0;
        end
      end else begin
        m_buf[m_len] = i_rx_byte;
        m_len++;
        if (m_len == (m_wr ? 10 : 6)) begin
          m_addr  = {m_buf[2], m_buf[3], m_buf[4], m_buf[5]};
          m_wdata = m_wr ? {m_buf[6], m_buf[7], m_buf[8], m_buf[9]} : 32'd0;
          m_pending = 1; m_len = 0;
        end
      end
    end else begin
      m_idle++;
      if (m_idle == TO) begin
        e_to = 1; m_len = 0;
      end
    end
  end

  // Per-cycle comparison, away from the active edge
  always @(negedge i_clk) begin
    if (cmp_en) begin
      chk("cmp_valid", o_cmd_valid, m_pending);
      chk("cmp_err_frame", o_err_frame, e_frame);
      chk("cmp_err_timeout", o_err_timeout, e_to);
      chk("cmp_err_overrun", o_err_overrun, e_ov);
      if (m_pending && o_cmd_valid) begin
        chk("cmp_wr", o_cmd_wr, m_wr);
        chk("cmp_addr", o_cmd_addr, m_addr);
        chk("cmp_wdata", o_cmd_wdata, m_wdata);
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    i_rx_dv = 1'b1;
    i_rx_byte = b;
    tick();
    i_rx_dv = 1'b0;
  endtask

  task automatic send_q(input logic [7:0] q[$]);
    foreach (q[i]) send(q[i]);
  endtask

  task automatic rand_gap(input int g);
    repeat (g) begin
      i_cmd_ready = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  task automatic rand_frame();
    logic [7:0] q[$];
    logic [7:0] b;
    int kind;
    int g;
    kind = $urandom_range(0, 5);
    case (kind)
      0, 5: begin q = {8'hA5, 8'h01}; repeat (8) q.push_back(8'($urandom)); end
      1:    begin q = {8'hA5, 8'h02}; repeat (4) q.push_back(8'($urandom)); end
      2: begin
        do b = 8'($urandom); while (b == 8'h01 || b == 8'h02);
        q = {8'hA5, b};
      end
      3: repeat ($urandom_range(1, 3)) q.push_back(8'($urandom));
      default: begin
        q = {8'hA5, 8'($urandom_range(1, 2))};
        repeat ($urandom_range(0, 5)) q.push_back(8'($urandom));
      end
    endcase
    foreach (q[i]) begin
      i_cmd_ready = 1'($urandom_range(0, 1));
      send(q[i]);
      if ($urandom_range(0, 7) == 0) g = $urandom_range(TO - 3, TO + 1);
      else g = $urandom_range(0, 2);
      rand_gap(g);
    end
    rand_gap(kind == 4 ? TO + 5 : $urandom_range(0, 8));
  endtask

  int k;

  initial begin
    i_rst_n = 1'b0; i_rx_dv = 1'b0; i_rx_byte = 8'h00; i_cmd_ready = 1'b0;
    tick(); tick();
    cmp_en = 1;
    chk("reset_valid", o_cmd_valid, 0);
    chk("reset_addr", o_cmd_addr, 0);
    chk("reset_wdata", o_cmd_wdata, 0);
    chk("reset_errs", {o_err_frame, o_err_timeout, o_err_overrun, o_cmd_wr}, 0);
    i_rst_n = 1'b1;
    tick();

    // Write frame with ready high
    i_cmd_ready = 1'b1;
    send_q({8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE});
    chk("wr_not_yet", o_cmd_valid, 0);
    send(8'hEF);
    chk("wr_valid", o_cmd_valid, 1);
    chk("wr_wr", o_cmd_wr, 1);
    chk("wr_addr", o_cmd_addr, 32'h12345678);
    chk("wr_wdata", o_cmd_wdata, 32'hDEADBEEF);
    tick();
    chk("wr_drop", o_cmd_valid, 0);

    // Read with backpressure
    i_cmd_ready = 1'b0;
    send_q({8'hA5, 8'h02, 8'h00, 8'h00, 8'h10, 8'h00});
    repeat (20) begin
      chk("bp_valid", o_cmd_valid, 1);
      chk("bp_addr", o_cmd_addr, 32'h00001000);
      chk("bp_wdata", o_cmd_wdata, 0);
      chk("bp_wr", o_cmd_wr, 0);
      tick();
    end
    i_cmd_ready = 1'b1;
    tick();
    chk("bp_drop", o_cmd_valid, 0);

    // Junk, bad opcode, then a read
    send(8'h00); send(8'hFF); send(8'hA5);
    send(8'h07);
    chk("badop_err", o_err_frame, 1);
    send_q({8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h04});
    chk("badop_read_valid", o_cmd_valid, 1);
    chk("badop_read_addr", o_cmd_addr, 32'h4);
    tick();

    // Timeout: error exactly TO cycles after the last byte
    send_q({8'hA5, 8'h01, 8'hAA});
    k = 0;
    while (!o_err_timeout && k < 200) begin
      tick();
      k++;
    end
    chk("timeout_delay", k, TO);
    tick();
    send_q({8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08});
    chk("after_to_addr", o_cmd_addr, 32'h01020304);
    chk("after_to_wdata", o_cmd_wdata, 32'h05060708);
    tick();

    // Overrun while a read is pending
    i_cmd_ready = 1'b0;
    send_q({8'hA5, 8'h02, 8'h0A, 8'h0B, 8'h0C, 8'h0D});
    tick();
    send(8'h55);
    chk("ovr_err", o_err_overrun, 1);
    chk("ovr_addr", o_cmd_addr, 32'h0A0B0C0D);
    tick();
    chk("ovr_err_once", o_err_overrun, 0);
    i_cmd_ready = 1'b1;
    tick();
    chk("ovr_drop", o_cmd_valid, 0);

    // Reset mid-frame
    send_q({8'hA5, 8'h01, 8'h11, 8'h22});
    i_rst_n = 1'b0;
    tick();
    chk("rst_outs", {o_cmd_valid, o_cmd_wr, o_err_frame, o_err_timeout, o_err_overrun}, 0);
    chk("rst_addr", o_cmd_addr, 0);
    i_rst_n = 1'b1;
    send_q({8'hA5, 8'h02, 8'hCA, 8'hFE, 8'hF0, 8'h0D});
    chk("rst_read_addr", o_cmd_addr, 32'hCAFEF00D);
    chk("rst_read_valid", o_cmd_valid, 1);
    tick();

    // Random frames
    repeat (200) rand_frame();
    i_cmd_ready = 1'b1;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Byte-stream command parser that sits directly downstream of the UART receiver. It consumes the receiver's one-cycle byte-valid pulses and frames them into DDR access commands: a sync byte, an opcode, a 32-bit address, and 32-bit write data for writes. Each complete command is presented to the DDR command stage on a valid/ready handshake. Malformed, stalled or overrunning frames are discarded and flagged.

## Interface
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `OP_WRITE`, default 8'h01: write opcode.
- `OP_READ`, default 8'h02: read opcode.
- `TIMEOUT_CLKS`, default 86800 (10 byte times at 868 clk/bit): maximum idle gap allowed between bytes inside a frame. Must be ≥ 2.
- `i_clk`  in  1  system clock; all logic is on its rising edge.
- `i_rst_n`  in  1  reset, synchronous, active-low.
- `i_rx_dv`  in  1  one-cycle byte-valid pulse from the UART receiver.
- `i_rx_byte`  in  8  received byte; sampled only when `i_rx_dv`=1.
- `o_cmd_valid`  out  1  command available.
- `i_cmd_ready`  in  1  downstream accepts the command.
- `o_cmd_wr`  out  1  1 = write, 0 = read.
- `o_cmd_addr`  out  32  address; the first address byte received is the MSB.
- `o_cmd_wdata`  out  32  write data; the first data byte is the MSB; 0 for reads.
- `o_err_frame`  out  1  one-cycle pulse: bad opcode.
- `o_err_timeout`  out  1  one-cycle pulse: inter-byte gap expired.
- `o_err_overrun`  out  1  one-cycle pulse: byte dropped while a command was pending.

## Operation
- **States:**
  - `IDLE`: hunts for the sync byte.
  - `OPCODE`: takes the opcode byte.
  - `ADDR`: takes 4 address bytes.
  - `DATA`: takes 4 data bytes.
  - `ISSUE`: holds the command until accepted.
- **IDLE:**
  - A byte equal to `SYNC_BYTE` moves to `OPCODE`.
  - Any other byte is discarded silently, with no error.
- **OPCODE:**
  - `OP_WRITE` sets `wr`=1; `OP_READ` sets `wr`=0. Both move to `ADDR` and clear the byte counter.
  - Any other value pulses `o_err_frame` and returns to `IDLE`.
  - The offending byte is not re-examined as a sync byte, even if it equals `SYNC_BYTE`.
- **ADDR:**
  - Each byte updates addr = {addr[23:0], byte}.
  - A 2-bit counter counts the bytes. After the 4th byte (counter=3): a write moves to `DATA` with the counter cleared; a read moves to `ISSUE` with wdata cleared to 0.
- **DATA:** same shift scheme into wdata. After the 4th byte, moves to `ISSUE`.
- **Timeout (OPCODE, ADDR, DATA only):**
  - The gap counter clears on entry to the state and on every `i_rx_dv`.
  - Otherwise it increments by 1 each cycle.
  - When it equals `TIMEOUT_CLKS-1` in a cycle with no `i_rx_dv`: pulse `o_err_timeout`, return to `IDLE`, discard the partial frame.
  - In the same cycle, `i_rx_dv` takes priority and no timeout occurs.
  - Counter width is clog2(TIMEOUT_CLKS). The counter holds at 0 in `IDLE` and `ISSUE`.
- **ISSUE:**
  - `o_cmd_valid`=1. `o_cmd_wr`, `o_cmd_addr` and `o_cmd_wdata` are stable for the whole time valid is high.
  - Transfer occurs on `o_cmd_valid` & `i_cmd_ready`; the next state is `IDLE`.
  - Any `i_rx_dv` while in `ISSUE`, including the transfer cycle, is dropped and pulses `o_err_overrun`. Frame sync is therefore lost; the host must resend from the sync byte.
- **Output updates:** `o_cmd_*` fields change only while valid is low. They are not required to clear after a transfer; verification checks them only while valid is high.
- **Reset:** synchronous reset mid-frame or mid-`ISSUE` discards everything.
- **Error pulses:** at most one error pulse is asserted per cycle.

## Timing
- All outputs are registered.
- **Reset values:** `o_cmd_valid`=0, `o_cmd_wr`=0, `o_cmd_addr`=0, `o_cmd_wdata`=0, all `o_err_*`=0. State `IDLE`, counters 0.
- **Command latency:** last frame byte's `i_rx_dv` at cycle N → `o_cmd_valid`=1 at N+1.
- **Handshake:** with `i_cmd_ready` held high, the transfer is at N+1 and valid is 0 at N+2. `i_cmd_ready` may be high while valid is low; this has no effect.
- **Error pulses:** each is high for exactly the one cycle after the causing event (bad opcode byte's dv cycle, timeout cycle, or dropped byte's dv cycle).
- **Back-to-back bytes:** one byte per cycle must be accepted. The receiver rate (one byte per ~8680 clocks) is far below this.
- **Next frame:** the sync byte is accepted from the cycle after the transfer, i.e. when the state is `IDLE`.

## Test plan
- **Write frame:** reset, then bytes A5 01 12 34 56 78 DE AD BE EF with ready=1 → one valid cycle with wr=1, addr=0x12345678, wdata=0xDEADBEEF, valid exactly 1 cycle after the EF dv; no error pulses.
- **Read with backpressure:** bytes A5 02 00 00 10 00 with ready=0 for 20 cycles → valid held high and addr=0x00001000, wdata=0, wr=0 stable all 20 cycles. Raise ready → valid drops the next cycle.
- **Bad opcode and junk:** bytes 00 FF A5 07 → no error for the leading junk bytes. The 07 gives one `o_err_frame` pulse and the state returns to `IDLE`. A following A5 02 00 00 00 04 yields a read with addr=4.
- **Timeout:** with TIMEOUT_CLKS=50, send A5 01 AA then stall → `o_err_timeout` pulses exactly 50 cycles after the AA dv. Then send a complete new frame → correct command, with no leftover bytes from the aborted frame.
- **Overrun:** hold ready=0 after a complete read frame, then send byte 55 → `o_err_overrun` pulses once and the command is unchanged. Raise ready → single transfer.
- **Reset mid-frame:** assert `i_rst_n`=0 for 1 cycle after A5 01 11 22 → all outputs 0. Then a full read frame for addr 0xCAFEF00D produces only that command.
